// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: stall/bubble/flush control plus load lane-select and extension.
// Optional HI/LO fields are built only when MEMWB_HILO_EN is defined.
module mem_wb_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall_current_stage,
  input  logic              stall_next_stage,
  input  logic              mem_read_flag_in,
  input  logic              mem_sign_ext_flag_in,
  input  logic [3:0]        mem_sel_in,
  input  logic [DATA_W-1:0] result_in,
  input  logic              reg_write_en_in,
  input  logic [REG_AW-1:0] reg_write_addr_in,
  input  logic [DATA_W-1:0] current_pc_addr_in,
  input  logic              hilo_write_en_in,
  input  logic [DATA_W-1:0] hi_in,
  input  logic [DATA_W-1:0] lo_in,
  input  logic [DATA_W-1:0] ram_read_data,
  output logic              reg_write_en_out,
  output logic [REG_AW-1:0] reg_write_addr_out,
  output logic [DATA_W-1:0] reg_write_data_out,
  output logic              mem_load_flag_wb,
  output logic [DATA_W-1:0] current_pc_addr_out,
  output logic              hilo_write_en_out,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);

  logic              load_flag_q;
  logic              sign_ext_q;
  logic [3:0]        sel_q;
  logic [DATA_W-1:0] result_q;
  logic              reg_we_q;
  logic [REG_AW-1:0] reg_waddr_q;
  logic [DATA_W-1:0] pc_q;
  logic              hold_valid_q;
  logic [DATA_W-1:0] hold_data_q;

  logic do_bubble;
  logic do_hold;

  always_comb begin
    do_bubble = flush || (stall_current_stage && !stall_next_stage);
    do_hold   = !flush && stall_current_stage && stall_next_stage;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_flag_q <= 1'b0;
      sign_ext_q  <= 1'b0;
      sel_q       <= '0;
      result_q    <= '0;
      reg_we_q    <= 1'b0;
      reg_waddr_q <= '0;
      pc_q        <= '0;
    end else if (do_bubble) begin
      load_flag_q <= 1'b0;
      sign_ext_q  <= 1'b0;
      sel_q       <= '0;
      result_q    <= '0;
      reg_we_q    <= 1'b0;
      reg_waddr_q <= '0;
      pc_q        <= '0;
    end else if (!do_hold) begin
      load_flag_q <= mem_read_flag_in;
      sign_ext_q  <= mem_sign_ext_flag_in;
      sel_q       <= mem_sel_in;
      result_q    <= result_in;
      reg_we_q    <= reg_write_en_in;
      reg_waddr_q <= reg_write_addr_in;
      pc_q        <= current_pc_addr_in;
    end
  end

  // The RAM word is only valid for one cycle; snapshot it on the first held edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else if (do_hold) begin
      if (load_flag_q && !hold_valid_q) begin
        hold_valid_q <= 1'b1;
        hold_data_q  <= ram_read_data;
      end
    end else begin
      hold_valid_q <= 1'b0;
    end
  end

`ifdef MEMWB_HILO_EN
  logic              hilo_we_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hilo_we_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else if (do_bubble) begin
      hilo_we_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else if (!do_hold) begin
      hilo_we_q <= hilo_write_en_in;
      hi_q      <= hi_in;
      lo_q      <= lo_in;
    end
  end

  assign hilo_write_en_out = hilo_we_q;
  assign hi_out            = hi_q;
  assign lo_out            = lo_q;
`else
  logic unused_hilo;
  assign unused_hilo       = ^{hilo_write_en_in, hi_in, lo_in};
  assign hilo_write_en_out = 1'b0;
  assign hi_out            = '0;
  assign lo_out            = '0;
`endif

  logic [DATA_W-1:0] ld_word;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] wdata;

  always_comb begin
    ld_word = hold_valid_q ? hold_data_q : ram_read_data;
    case (result_q[1:0])
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = result_q[1] ? ld_word[31:16] : ld_word[15:0];

    wdata = '0;
    if (!load_flag_q) begin
      wdata = result_q;
    end else begin
      case (sel_q)
        4'b0001: wdata = {{(DATA_W-8){sign_ext_q & ld_byte[7]}}, ld_byte};
        4'b0011: begin
          if (!result_q[0]) wdata = {{(DATA_W-16){sign_ext_q & ld_half[15]}}, ld_half};
        end
        4'b1111: begin
          if (result_q[1:0] == 2'b00) wdata = ld_word;
        end
        default: wdata = '0;
      endcase
    end
  end

  assign reg_write_en_out    = reg_we_q;
  assign reg_write_addr_out  = reg_waddr_q;
  assign reg_write_data_out  = wdata;
  assign mem_load_flag_wb    = load_flag_q;
  assign current_pc_addr_out = pc_q;

endmodule
